// File: rtl/ase_umsg_sched_pkg.sv
// Shared CCI-P Rx0 types and constants for the UMsg scheduler, plus a UMsg header builder.
package ase_umsg_sched_pkg;

  localparam int CCIP_DATA_WIDTH       = 512;
  localparam int CCIP_RX_HDR_WIDTH     = 28;
  localparam int CCIP_UMSG_BITINDEX    = 12;
  localparam int UMSG_DELAY_TIMER_LOG2 = 8;
  localparam int NUM_UMSG_DEFAULT      = 32;
  localparam int UMSG_HINT_BIT         = CCIP_UMSG_BITINDEX;

  localparam logic [3:0] CCIP_RX0_UMSG = 4'hF;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        poison;
    logic        hitmiss;
    logic        format;
    logic        rsvd22;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;

  typedef enum logic [2:0] {
    UMsg_Idle,
    UMsg_ChangeOccured,
    UMsg_SendHint,
    UMsg_Waiting,
    UMsg_SendData
  } UMsg_StateEnum;

  typedef struct packed {
    logic                       change;
    logic [CCIP_DATA_WIDTH-1:0] data;
  } umsg_t;

  // Slot id must stay below the hint bit, which holds for any slot count up to 4096.
  function automatic RxHdr_t umsg_hdr(input logic [15:0] id, input logic hint);
    RxHdr_t h;
    h                      = '0;
    h.resptype             = CCIP_RX0_UMSG;
    h.mdata                = id;
    h.mdata[UMSG_HINT_BIT] = hint;
    return h;
  endfunction

endpackage

// File: rtl/ase_umsg_slot.sv
// One UMsg slot: latches software writes and walks the hint/data state machine.
// hint_ready/data_ready are held until the matching pop; a write never loses its data.
module ase_umsg_slot
  import ase_umsg_sched_pkg::*;
#(
  parameter int TIMER_W    = UMSG_DELAY_TIMER_LOG2,
  parameter int HINT_DELAY = 2,
  parameter int DATA_DELAY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [CCIP_DATA_WIDTH-1:0] wr_data,
  input  logic                       hint_en,
  input  logic                       hint_pop,
  input  logic                       data_pop,
  output logic                       hint_ready,
  output logic                       data_ready,
  output logic                       busy,
  output logic [CCIP_DATA_WIDTH-1:0] data,
  output logic [CCIP_DATA_WIDTH-1:0] data_last
);

  localparam logic [TIMER_W-1:0] HINT_LOAD = TIMER_W'(HINT_DELAY);
  localparam logic [TIMER_W-1:0] DATA_LOAD = TIMER_W'(DATA_DELAY);

  UMsg_StateEnum              state, state_nxt;
  umsg_t                      umsg, umsg_nxt;
  logic [TIMER_W-1:0]         hint_timer, hint_timer_nxt;
  logic [TIMER_W-1:0]         data_timer, data_timer_nxt;
  logic [CCIP_DATA_WIDTH-1:0] data_q, data_q_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UMsg_Idle;
      umsg       <= '0;
      hint_timer <= '0;
      data_timer <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nxt;
      umsg       <= umsg_nxt;
      hint_timer <= hint_timer_nxt;
      data_timer <= data_timer_nxt;
      data_q     <= data_q_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    umsg_nxt       = umsg;
    hint_timer_nxt = hint_timer;
    data_timer_nxt = data_timer;
    data_q_nxt     = data_q;

    // Latest write always wins the data register, whatever the state.
    if (wr_en) umsg_nxt.data = wr_data;

    case (state)
      UMsg_Idle: begin
        if (wr_en) umsg_nxt.change = 1'b1;
        if (umsg.change) state_nxt = UMsg_ChangeOccured;
      end
      UMsg_ChangeOccured: begin
        if (hint_en) begin
          hint_timer_nxt = HINT_LOAD;
          state_nxt      = UMsg_SendHint;
        end else begin
          data_timer_nxt = DATA_LOAD;
          state_nxt      = UMsg_Waiting;
        end
      end
      UMsg_SendHint: begin
        if (hint_timer != '0) begin
          hint_timer_nxt = hint_timer - 1'b1;
        end else if (hint_pop) begin
          data_timer_nxt = DATA_LOAD;
          state_nxt      = UMsg_Waiting;
        end
      end
      UMsg_Waiting: begin
        if (data_timer != '0) data_timer_nxt = data_timer - 1'b1;
        else                  state_nxt      = UMsg_SendData;
      end
      UMsg_SendData: begin
        // The popped packet carries the current data; a same-cycle write restarts the slot.
        if (data_pop) begin
          data_q_nxt = umsg.data;
          if (wr_en) begin
            umsg_nxt.change = 1'b1;
            state_nxt       = UMsg_ChangeOccured;
          end else begin
            umsg_nxt.change = 1'b0;
            state_nxt       = UMsg_Idle;
          end
        end
      end
      default: state_nxt = UMsg_Idle;
    endcase
  end

  assign hint_ready = (state == UMsg_SendHint) && (hint_timer == '0);
  assign data_ready = (state == UMsg_SendData);
  assign busy       = (state != UMsg_Idle);
  assign data       = umsg.data;
  assign data_last  = data_q;

endmodule

// File: rtl/ase_umsg_sched.sv
// Per-slot UMsg hint/data scheduler driving a registered Rx0 valid/ready output.
// Hints outrank data; round-robin within a class; output holds while valid && !ready.
module ase_umsg_sched
  import ase_umsg_sched_pkg::*;
#(
  parameter int NUM_UMSG   = NUM_UMSG_DEFAULT,
  parameter int UMSG_ID_W  = $clog2(NUM_UMSG),
  parameter int TIMER_W    = UMSG_DELAY_TIMER_LOG2,
  parameter int HINT_DELAY = 2,
  parameter int DATA_DELAY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         umsg_wr_valid,
  input  logic [UMSG_ID_W-1:0]         umsg_wr_id,
  input  logic [CCIP_DATA_WIDTH-1:0]   umsg_wr_data,
  input  logic [NUM_UMSG-1:0]          umsg_hint_en,
  output logic                         umsg_out_valid,
  output logic [CCIP_RX_HDR_WIDTH-1:0] umsg_out_hdr,
  output logic [CCIP_DATA_WIDTH-1:0]   umsg_out_data,
  input  logic                         umsg_out_ready,
  output logic [NUM_UMSG-1:0]          umsg_slot_busy
);

  logic [NUM_UMSG-1:0]        hint_ready, data_ready, hint_pop, data_pop;
  logic [CCIP_DATA_WIDTH-1:0] slot_data      [NUM_UMSG];
  logic [CCIP_DATA_WIDTH-1:0] slot_data_last [NUM_UMSG];

  for (genvar i = 0; i < NUM_UMSG; i++) begin : g_slot
    ase_umsg_slot #(
      .TIMER_W    (TIMER_W),
      .HINT_DELAY (HINT_DELAY),
      .DATA_DELAY (DATA_DELAY)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (umsg_wr_valid && (umsg_wr_id == UMSG_ID_W'(i))),
      .wr_data    (umsg_wr_data),
      .hint_en    (umsg_hint_en[i]),
      .hint_pop   (hint_pop[i]),
      .data_pop   (data_pop[i]),
      .hint_ready (hint_ready[i]),
      .data_ready (data_ready[i]),
      .busy       (umsg_slot_busy[i]),
      .data       (slot_data[i]),
      .data_last  (slot_data_last[i])
    );
  end

  logic [UMSG_ID_W-1:0] rr_ptr, gnt_id, idx;
  logic                 gnt_vld, gnt_hint, load;

  assign load = !umsg_out_valid || umsg_out_ready;

  // Scan from the pointer; the id width wraps the index for free.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_hint = 1'b0;
    gnt_id   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_UMSG; k++) begin
      idx = rr_ptr + UMSG_ID_W'(k);
      if (!gnt_vld && hint_ready[idx]) begin
        gnt_vld  = 1'b1;
        gnt_hint = 1'b1;
        gnt_id   = idx;
      end
    end
    for (int k = 0; k < NUM_UMSG; k++) begin
      idx = rr_ptr + UMSG_ID_W'(k);
      if (!gnt_vld && data_ready[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    hint_pop = '0;
    data_pop = '0;
    if (load && gnt_vld) begin
      if (gnt_hint) hint_pop[gnt_id] = 1'b1;
      else          data_pop[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      umsg_out_valid <= 1'b0;
      umsg_out_hdr   <= '0;
      umsg_out_data  <= '0;
      rr_ptr         <= '0;
    end else if (load) begin
      umsg_out_valid <= gnt_vld;
      if (gnt_vld) begin
        umsg_out_hdr  <= umsg_hdr(16'(gnt_id), gnt_hint);
        umsg_out_data <= gnt_hint ? '0 : slot_data[gnt_id];
        rr_ptr        <= gnt_id + 1'b1;
      end
    end
  end

  // A pending data packet always matches the snapshot its slot took when popped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(umsg_wr_valid))
        else $fatal(1, "umsg_wr_valid is X/Z");
      if (umsg_out_valid && !umsg_out_hdr[UMSG_HINT_BIT])
        assert (umsg_out_data == slot_data_last[umsg_out_hdr[UMSG_ID_W-1:0]])
          else $error("umsg data packet does not match slot snapshot");
    end
  end

endmodule
